// File: rtl/gtfraw_vnc_event_pacer_pkg.sv
// -----------------------------------------------------------------------------
// gtfraw_vnc_event_pacer_pkg
// Shared types and constants for the event pacer that feeds the clkin-side
// pulse synchronizer.
//   pacer_state_t  : IDLE / PULSE / GAP state encoding
//   STATS_W        : width of the optional statistics counters
//   gap_cnt_width  : width needed to hold GAP_CYCLES in the gap timer
// -----------------------------------------------------------------------------
package gtfraw_vnc_event_pacer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } pacer_state_t;

   localparam int STATS_W = 32;

   // Holds values 0..gap_cycles without wrapping; never narrower than 1 bit.
   function automatic int gap_cnt_width(input int gap_cycles);
      int w;
      w = $clog2(gap_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gtfraw_vnc_pacer_gap_timer.sv
// -----------------------------------------------------------------------------
// gtfraw_vnc_pacer_gap_timer
// Load/decrement timer that measures the forced idle gap after each pulse.
// Ports:
//   clk   : source-domain clock
//   reset : asynchronous active-high reset
//   load  : loads GAP_CYCLES (asserted on the transition into GAP)
//   run   : decrement enable (asserted while in GAP)
//   done  : count has reached 1, i.e. this is the last gap cycle
// -----------------------------------------------------------------------------
module gtfraw_vnc_pacer_gap_timer
   import gtfraw_vnc_event_pacer_pkg::*;
#(
   parameter int GAP_CYCLES = 16
)(
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic run,
   output logic done
);

   localparam int GW = gap_cnt_width(GAP_CYCLES);
   localparam logic [GW-1:0] LOAD_VAL = GW'(GAP_CYCLES);
   localparam logic [GW-1:0] ONE      = GW'(1);

   logic [GW-1:0] cnt_reg;
   logic [GW-1:0] cnt_next;

   // Stops at 1 so the counter can never wrap, even if run stays high.
   always_comb begin
      cnt_next = cnt_reg;
      if (load) begin
         cnt_next = LOAD_VAL;
      end else if (run && (cnt_reg > ONE)) begin
         cnt_next = cnt_reg - ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign done = (cnt_reg == ONE);

endmodule

// File: rtl/gtfraw_vnc_event_pacer.sv
// -----------------------------------------------------------------------------
// gtfraw_vnc_event_pacer
// Accumulates per-cycle event counts into a saturating pending counter and
// re-emits them as single-cycle pulses spaced at least GAP_CYCLES+1 apart, so
// the downstream req/ack pulse synchronizer never drops an edge.
// Ports:
//   clk            : source-domain clock (synchronizer clkin)
//   reset          : asynchronous active-high reset
//   event_inc      : number of events this cycle (0 = none)
//   clear_ovf      : strobe, clears overflow (and statistics when enabled)
//   pulse_out      : registered one-cycle pulse to synchronizer pulsein
//   pending        : registered count of events not yet emitted
//   busy           : state != IDLE or pending != 0
//   overflow       : sticky, set when an event was lost to saturation
//   total_events   : (GTFRAW_VNC_EVENT_PACER_STATS_EN) sum of all event_inc
//   dropped_events : (GTFRAW_VNC_EVENT_PACER_STATS_EN) events lost to saturation
// -----------------------------------------------------------------------------
module gtfraw_vnc_event_pacer
   import gtfraw_vnc_event_pacer_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int INC_W      = 2,
   parameter int GAP_CYCLES = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [INC_W-1:0] event_inc,
   input  logic             clear_ovf,
   output logic             pulse_out,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             overflow
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
   ,
   output logic [STATS_W-1:0] total_events,
   output logic [STATS_W-1:0] dropped_events
`endif
);

   generate
      if (GAP_CYCLES < 1) begin : g_gap_check
         $error("gtfraw_vnc_event_pacer: GAP_CYCLES must be at least 1");
      end
   endgenerate

   localparam int SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] PEND_MAX = {1'b0, {CNT_W{1'b1}}};

   pacer_state_t     state_reg, state_next;
   logic [CNT_W-1:0] pending_reg, pending_next;
   logic             overflow_reg, overflow_next;
   logic             pulse_reg;
   logic             dec;
   logic             gap_load;
   logic             gap_done;
   logic [SUM_W-1:0] raw_sum;
   logic [SUM_W-1:0] net_sum;
   logic             sat;

   gtfraw_vnc_pacer_gap_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap_timer (
      .clk   (clk),
      .reset (reset),
      .load  (gap_load),
      .run   (state_reg == GAP),
      .done  (gap_done)
   );

   // raw_sum excludes the decrement: the decision to fire at the end of a gap
   // looks at whether anything is available this cycle, and firing is what
   // creates the decrement.
   assign raw_sum = {1'b0, pending_reg} + SUM_W'(event_inc);

   always_comb begin
      state_next = state_reg;
      dec        = 1'b0;
      gap_load   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (pending_reg != '0) begin
               state_next = PULSE;
               dec        = 1'b1;
            end
         end
         PULSE: begin
            state_next = GAP;
            gap_load   = 1'b1;
         end
         GAP: begin
            if (gap_done) begin
               if (raw_sum != '0) begin
                  state_next = PULSE;
                  dec        = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // dec is only raised when raw_sum is nonzero, so net_sum cannot underflow.
   assign net_sum = raw_sum - SUM_W'(dec);
   assign sat     = (net_sum > PEND_MAX);

   always_comb begin
      pending_next  = sat ? PEND_MAX[CNT_W-1:0] : net_sum[CNT_W-1:0];
      overflow_next = overflow_reg;
      if (sat) begin
         overflow_next = 1'b1;      // a new loss beats a simultaneous clear
      end else if (clear_ovf) begin
         overflow_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         pending_reg  <= '0;
         overflow_reg <= 1'b0;
         pulse_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pending_reg  <= pending_next;
         overflow_reg <= overflow_next;
         pulse_reg    <= (state_next == PULSE);
      end
   end

   assign pulse_out = pulse_reg;
   assign pending   = pending_reg;
   assign overflow  = overflow_reg;
   assign busy      = (state_reg != IDLE) || (pending_reg != '0);

`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
   logic [STATS_W-1:0] total_reg, total_next;
   logic [STATS_W-1:0] dropped_reg, dropped_next;
   logic [STATS_W-1:0] drop_now;

   assign drop_now = sat ? STATS_W'(net_sum - PEND_MAX) : '0;

   // A clear restarts both counters from this cycle's activity, so events
   // arriving alongside the clear are still accounted for.
   always_comb begin
      if (clear_ovf) begin
         total_next   = STATS_W'(event_inc);
         dropped_next = drop_now;
      end else begin
         total_next   = total_reg + STATS_W'(event_inc);
         dropped_next = dropped_reg + drop_now;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_reg   <= '0;
         dropped_reg <= '0;
      end else begin
         total_reg   <= total_next;
         dropped_reg <= dropped_next;
      end
   end

   assign total_events   = total_reg;
   assign dropped_events = dropped_reg;
`endif

endmodule

// File: tb/tb_gtfraw_vnc_event_pacer.sv
// -----------------------------------------------------------------------------
// tb_gtfraw_vnc_event_pacer
// Directed scenarios plus randomized traffic, checked every cycle against a
// timestamp-based reference model of the pacing rules.
// -----------------------------------------------------------------------------
module tb_gtfraw_vnc_event_pacer;

   localparam int CNT_W      = 4;
   localparam int INC_W      = 2;
   localparam int GAP_CYCLES = 16;
   localparam int MAXP       = (1 << CNT_W) - 1;
   localparam int HIST       = 1024;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [INC_W-1:0] event_inc = '0;
   logic             clear_ovf = 1'b0;
   logic             pulse_out;
   logic [CNT_W-1:0] pending;
   logic             busy;
   logic             overflow;
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
   logic [31:0]      total_events;
   logic [31:0]      dropped_events;
`endif

   gtfraw_vnc_event_pacer #(
      .CNT_W      (CNT_W),
      .INC_W      (INC_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .event_inc      (event_inc),
      .clear_ovf      (clear_ovf),
      .pulse_out      (pulse_out),
      .pending        (pending),
      .busy           (busy),
      .overflow       (overflow)
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
      ,
      .total_events   (total_events),
      .dropped_events (dropped_events)
`endif
   );

   always #5 clk = ~clk;

   int test_cnt = 0;
   int fail_cnt = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      test_cnt++;
      if (obs != exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Pacing is expressed with timestamps: m_last is the cycle in which the
   // most recent pulse was high. A new pulse may be decided from cycle
   // m_last+GAP onward; at exactly m_last+GAP that cycle's arrivals count.
   int          m_pend, m_last, m_cyc, m_pulses;
   bit          m_ovf, m_pulse, m_busy;
   int unsigned m_total, m_drop;

   task automatic model_reset();
      m_pend = 0; m_last = -100000; m_cyc = 0;
      m_ovf = 0; m_pulse = 0; m_busy = 0;
      m_total = 0; m_drop = 0;
   endtask

   task automatic model_step(input int inc, input bit clr);
      int sum, drop;
      bit fire;
      if (m_cyc < m_last + GAP_CYCLES)       fire = 0;
      else if (m_cyc == m_last + GAP_CYCLES) fire = (m_pend + inc) > 0;
      else                                   fire = m_pend > 0;
      sum  = m_pend + inc - int'(fire);
      drop = (sum > MAXP) ? sum - MAXP : 0;
      m_pend = (sum > MAXP) ? MAXP : sum;
      if (drop > 0)  m_ovf = 1;
      else if (clr)  m_ovf = 0;
      if (clr) begin
         m_total = inc; m_drop = drop;
      end else begin
         m_total += inc; m_drop += drop;
      end
      m_pulse = fire;
      if (fire) begin
         m_last = m_cyc + 1;
         m_pulses++;
      end
      m_cyc++;
      m_busy = ((m_cyc >= m_last) && (m_cyc <= m_last + GAP_CYCLES)) || (m_pend != 0);
   endtask

   task automatic check_all();
      check_val("pulse_out", pulse_out, m_pulse);
      check_val("pending",   pending,   m_pend);
      check_val("busy",      busy,      m_busy);
      check_val("overflow",  overflow,  m_ovf);
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
      check_val("total_events",   total_events,   m_total);
      check_val("dropped_events", dropped_events, m_drop);
`endif
   endtask

   // ---------------- observation history ----------------
   int rel_cyc;
   int pulse_q[$];
   int obs_pend[HIST];
   bit obs_busy[HIST];
   bit obs_ovf[HIST];

   task automatic start_scenario();
      rel_cyc = 0;
      pulse_q.delete();
   endtask

   // One clock: apply inputs, advance model with the same inputs, compare.
   task automatic step(input int inc, input bit clr);
      event_inc = INC_W'(inc);
      clear_ovf = clr;
      @(posedge clk);
      model_step(inc, clr);
      #1;
      rel_cyc++;
      check_all();
      if (pulse_out) pulse_q.push_back(rel_cyc);
      if (rel_cyc < HIST) begin
         obs_pend[rel_cyc] = int'(pending);
         obs_busy[rel_cyc] = busy;
         obs_ovf[rel_cyc]  = overflow;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      event_inc = '0;
      clear_ovf = 1'b0;
      #2;
      model_reset();
      check_val("rst_pulse_out", pulse_out, 0);
      check_val("rst_pending",   pending,   0);
      check_val("rst_busy",      busy,      0);
      check_val("rst_overflow",  overflow,  0);
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
      check_val("rst_total",   total_events,   0);
      check_val("rst_dropped", dropped_events, 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   int bl_exp[5] = '{2, 19, 36, 53, 70};

   initial begin
      model_reset();
      #1;
      do_reset();

      // Single event
      start_scenario();
      step(1, 0);
      idle(30);
      check_val("single_pend_n1",  obs_pend[1], 1);
      check_val("single_pend_n2",  obs_pend[2], 0);
      check_val("single_npulses",  pulse_q.size(), 1);
      check_val("single_pulse_at", (pulse_q.size() > 0) ? pulse_q[0] : -1, 2);
      check_val("single_busy_n18", obs_busy[18], 1);
      check_val("single_busy_n19", obs_busy[19], 0);
      $display("[TB] single event: %0d pulse(s)", pulse_q.size());

      // Backlog of 5
      start_scenario();
      step(3, 0);
      step(2, 0);
      idle(100);
      check_val("backlog_npulses", pulse_q.size(), 5);
      for (int i = 0; i < 5; i++)
         check_val("backlog_edge", (i < pulse_q.size()) ? pulse_q[i] : -1, bl_exp[i]);
      check_val("backlog_ovf", obs_ovf[100], 0);
      $display("[TB] backlog: %0d pulse(s)", pulse_q.size());

      // Saturation
      do_reset();
      start_scenario();
      for (int i = 0; i < 6; i++) step(3, 0);
      check_val("sat_pend", obs_pend[6], MAXP);
      check_val("sat_ovf",  obs_ovf[6], 1);
      idle(300);
      check_val("sat_npulses", pulse_q.size(), 1 + MAXP);
      check_val("sat_ovf_sticky", overflow, 1);
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
      check_val("sat_total",   total_events,   18);
      check_val("sat_dropped", dropped_events, 2);
`endif
      step(0, 1);
      check_val("sat_ovf_clr", overflow, 0);
`ifdef GTFRAW_VNC_EVENT_PACER_STATS_EN
      check_val("sat_total_clr",   total_events,   0);
      check_val("sat_dropped_clr", dropped_events, 0);
`endif
      $display("[TB] saturation: %0d pulse(s)", pulse_q.size());

      // Simultaneous increment and decrement at the end of a gap
      do_reset();
      start_scenario();
      step(3, 0);
      step(1, 0);
      idle(16);
      step(1, 0);
      check_val("incdec_pend",  obs_pend[19], 3);
      check_val("incdec_pulse", pulse_q.size() == 2 && pulse_q[1] == 19, 1);
      idle(80);
      $display("[TB] inc/dec overlap: %0d pulse(s)", pulse_q.size());

      // Reset in the middle of a gap with pending = 5
      do_reset();
      start_scenario();
      step(3, 0);
      step(3, 0);
      idle(3);
      check_val("midgap_pend_pre", pending, 5);
      do_reset();
      start_scenario();
      idle(20);
      check_val("midgap_no_pulse", pulse_q.size(), 0);
      $display("[TB] reset mid-gap: %0d pulse(s) after release", pulse_q.size());

      // Randomized traffic
      start_scenario();
      for (int i = 0; i < 4000; i++) begin
         int inc;
         bit clr;
         inc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         if ((i / 500) % 2 == 1 && $urandom_range(0, 1) == 1) inc = 3;
         clr = ($urandom_range(0, 49) == 0);
         step(inc, clr);
      end
      idle(400);
      $display("[TB] random traffic: %0d pulse(s)", pulse_q.size());

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
